// File: rtl/dmem_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder.
// Latency: n/a (declarations only). Backpressure: n/a.
package dmem_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_LATENCY    = 2;

  // Wait counter width; covers LATENCY values 0..15.
  localparam int CNT_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word storage with registered read data.
// Latency: 1 cycle read. Backpressure: none, accepts an access whenever en=1.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0]  wdata,
  output logic [DATA_WIDTH-1:0]  rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // rdata only moves on reads, so a write leaves the last read word visible.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[index] <= wdata;
      end else begin
        rdata <= mem[index];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store target with a fixed number of wait states; DMEM_RANGE_CHECK_EN adds addr>=DEPTH errors.
// Latency: ack in cycle N+LATENCY+1 after the accepting edge N. Backpressure: ready=0 until the ack cycle has passed.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  localparam int                   IDX_W   = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] LAT_CNT = CNT_WIDTH'(LATENCY);

  state_t                 state;
  state_t                 stateNext;
  logic [CNT_WIDTH-1:0]   waitCnt;
  logic                   heldWe;
  logic [ADDR_WIDTH-1:0]  heldAddr;
  logic [DATA_WIDTH-1:0]  heldWdata;
  logic                   accept;
  logic                   enterResp;
  logic                   accWe;
  logic [ADDR_WIDTH-1:0]  accAddr;
  logic [DATA_WIDTH-1:0]  accWdata;
  logic                   inRange;
  logic                   memEn;
  logic [DATA_WIDTH-1:0]  memRdata;
  logic                   rdZero;
  logic                   errQ;

  assign accept = (state == IDLE) && req;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req) stateNext = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (waitCnt == CNT_WIDTH'(1)) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign enterResp = (stateNext == RESP);

  // With zero wait states the access happens on the accepting edge itself,
  // before the holding registers are loaded, so take the request directly.
  assign accWe    = (state == IDLE) ? we    : heldWe;
  assign accAddr  = (state == IDLE) ? addr  : heldAddr;
  assign accWdata = (state == IDLE) ? wdata : heldWdata;

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  assign inRange = ({1'b0, accAddr} < DEPTH_LIM);
`else
  logic unusedAddrBits;
  assign unusedAddrBits = ^accAddr;
  assign inRange        = 1'b1;
`endif

  assign memEn = enterResp && inRange && !rst;

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INDEX_WIDTH(IDX_W)
  ) uArray (
    .clk  (clk),
    .en   (memEn),
    .we   (accWe),
    .index(accAddr[IDX_W-1:0]),
    .wdata(accWdata),
    .rdata(memRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      heldWe    <= 1'b0;
      heldAddr  <= '0;
      heldWdata <= '0;
      ack       <= 1'b0;
      errQ      <= 1'b0;
      rdZero    <= 1'b1;
    end else begin
      state <= stateNext;
      ack   <= enterResp;
      if (accept) begin
        heldWe    <= we;
        heldAddr  <= addr;
        heldWdata <= wdata;
        if (LATENCY != 0) waitCnt <= LAT_CNT;
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - CNT_WIDTH'(1);
      end
      if (enterResp) begin
        errQ <= !inRange;
        // The array output register is unreset; mask it until a real read lands.
        if (!inRange) begin
          rdZero <= 1'b1;
        end else if (!accWe) begin
          rdZero <= 1'b0;
        end
      end
    end
  end

  assign ready = (state == IDLE) && !rst;
  assign rdata = rdZero ? '0 : memRdata;
  assign err   = errQ;

endmodule
